fir_mc_core: RTL
================

FIR_MC_CORE -- requirements
Module: fir_mc_core

Interface
REQ-001 SHALL have parameter C_MAX_TAPS, default 16, the maximum number of taps per channel (power of 2, 2..64).
REQ-002 SHALL have parameter C_DATA_WIDTH, default 16, the width of each signed input sample.
REQ-003 SHALL have parameter C_COEF_WIDTH, default 16, the width of each signed coefficient.
REQ-004 SHALL have parameter C_NUM_CH, default 2, the number of independent channels (1..8).
REQ-005 SHALL derive C_ACC_WIDTH = C_DATA_WIDTH + C_COEF_WIDTH + clog2(C_MAX_TAPS) (36 at defaults).
REQ-006 SHALL have these ports, one per line as name, direction, width, meaning; one clock, reset asynchronous and active-low:
  s00_axi_aclk  in  1  sole clock, rising edge.
  s00_axi_aresetn  in  1  asynchronous active-low reset.
  cfg_tap_count  in  clog2(C_MAX_TAPS)+1  active taps T, sampled on input accept.
  coef_load_en  in  1  coefficient load mode.
  coef_wr  in  1  one-cycle coefficient write strobe.
  coef_data  in  C_COEF_WIDTH  signed coefficient.
  in_valid / in_ready  in / out  1  sample handshake.
  in_ch  in  clog2(C_NUM_CH) (min 1)  channel of sample.
  in_data  in  C_DATA_WIDTH  signed sample.
  out_valid / out_ready  out / in  1  result handshake.
  out_ch  out  clog2(C_NUM_CH) (min 1)  channel of result.
  out_data  out  C_ACC_WIDTH  signed full-precision result.
  busy  out  1  high in MAC or OUT.
  err  out  1  sticky: illegal tap count seen or coefficient overflow.

Function
REQ-007 SHALL implement FSM states IDLE, MAC, OUT; coefficient loading occurs only in IDLE.
REQ-008 IDLE with coef_load_en=1: each coef_wr SHALL write coef_data to coef[idx] and increment idx; idx SHALL reset to 0 on the rising edge of coef_load_en.
REQ-009 Writes with idx >= C_MAX_TAPS SHALL be dropped and set err.
REQ-010 Coefficients SHALL be shared by all channels.
REQ-011 in_ready SHALL be 1 only in IDLE with coef_load_en=0 and 1 <= cfg_tap_count <= C_MAX_TAPS.
REQ-012 cfg_tap_count of 0 or > C_MAX_TAPS SHALL hold in_ready=0 and set err.
REQ-013 If coef_load_en and in_valid are both high, the load SHALL win and no sample SHALL be accepted.
REQ-014 On accept (in_valid & in_ready), the sample SHALL shift into position 0 of the in_ch delay line; older samples shift toward position C_MAX_TAPS-1; other channels SHALL be untouched.
REQ-015 T and channel SHALL be latched on accept, and the FSM SHALL go to MAC.
REQ-016 MAC SHALL perform one signed multiply-accumulate per cycle, acc += coef[k] * x[ch][k] for k = 0..T-1, with the accumulator cleared at entry.
REQ-017 After T MAC cycles the FSM SHALL enter OUT with out_valid=1: accept in cycle N -> out_valid in cycle N+T+1.
REQ-018 In OUT, out_data and out_ch SHALL be held stable until out_valid & out_ready; IDLE SHALL follow the next cycle.
REQ-019 in_ready SHALL be 0 throughout MAC and OUT; out_ready SHALL be ignored outside OUT.
REQ-020 Arithmetic SHALL be full precision, with no saturation or truncation within C_ACC_WIDTH.
REQ-021 err SHALL clear only on reset.

Reset
REQ-022 Reset SHALL be asynchronous on s00_axi_aresetn low and SHALL force IDLE.
REQ-023 Reset SHALL clear coefficients, delay lines, accumulator, idx, and err to 0.
REQ-024 During reset, outputs SHALL be in_ready=0, out_valid=0, out_data=0, out_ch=0, busy=0, err=0.
REQ-025 Reset mid-MAC or mid-OUT SHALL discard the pending result, and no out_valid SHALL follow.

Structure
REQ-026 Package fir_pkg SHALL hold the FSM state enum, default parameter values, and the C_ACC_WIDTH derivation function.
REQ-027 One sub-module, fir_mac, SHALL implement the registered signed multiply-accumulate with a clear input.

Verification
REQ-028 T=4, coefficients {1,2,3,4}, ch0 impulse 1 followed by four 0s -> outputs 1,2,3,4,0 with out_ch=0.
REQ-029 Interleave ch1 samples of 5 between the ch0 impulse samples -> ch0 sequence is unchanged; ch1 outputs are 5,15,30,50.
REQ-030 Hold out_ready=0 for 10 cycles in OUT -> out_valid and out_data are stable and in_ready=0 throughout; the first accept after out_ready is the next sample.
REQ-031 Set cfg_tap_count=0, then 17 -> in_ready=0 and err=1; a 17th coefficient write sets err.
REQ-032 T=16, all coefficients and samples -32768 -> out_data = 2^34 exactly, with latency 17 cycles.
REQ-033 Assert reset at MAC cycle 2 -> no out_valid, all outputs 0; a post-reset impulse yields 0 because the coefficients are cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type, default sizing and accumulator width
// helper for the multichannel FIR core.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  localparam int DEF_MAX_TAPS   = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_COEF_WIDTH = 16;
  localparam int DEF_NUM_CH     = 2;

  // Product width plus growth bits for summing taps products.
  function automatic int acc_width(int dw, int cw, int taps);
    return dw + cw + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate with synchronous clear.
// Ports: clk, rst_n, clr, en, a, b in; acc out (full precision).
module fir_mac #(
  parameter int AW    = 16,
  parameter int BW    = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = AW + BW;

  logic signed [PW-1:0] prod;

  assign prod = PW'(a) * PW'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
  end

endmodule

// File: rtl/fir_mc_core.sv
// fir_mc_core: time-multiplexed FIR, one MAC per cycle, shared coefs,
// per-channel delay lines. Ports: coef load, sample/result handshakes, busy, err.
module fir_mc_core
  import fir_pkg::*;
#(
  parameter int C_MAX_TAPS   = DEF_MAX_TAPS,
  parameter int C_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int C_COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int C_NUM_CH     = DEF_NUM_CH,
  localparam int C_ACC_WIDTH =
    acc_width(C_DATA_WIDTH, C_COEF_WIDTH, C_MAX_TAPS),
  localparam int TW  = $clog2(C_MAX_TAPS) + 1,
  localparam int CHW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_aresetn,
  input  logic [TW-1:0]                  cfg_tap_count,
  input  logic                           coef_load_en,
  input  logic                           coef_wr,
  input  logic signed [C_COEF_WIDTH-1:0] coef_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHW-1:0]                 in_ch,
  input  logic signed [C_DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHW-1:0]                 out_ch,
  output logic signed [C_ACC_WIDTH-1:0]  out_data,
  output logic                           busy,
  output logic                           err
);

  localparam int KW = TW - 1;
  localparam logic [TW-1:0] MAXT = TW'(C_MAX_TAPS);

  fir_state_t state;

  logic [TW-1:0]  idx;
  logic [TW-1:0]  wr_idx;
  logic [TW-1:0]  t_lat;
  logic [KW-1:0]  k;
  logic [CHW-1:0] ch_lat;
  logic           load_q;
  logic           load_rise;
  logic           tap_ok;
  logic           accept;
  logic           mac_en;

  logic signed [C_COEF_WIDTH-1:0] coef [C_MAX_TAPS];
  logic signed [C_DATA_WIDTH-1:0] dline [C_NUM_CH][C_MAX_TAPS];

  // A write in the same cycle as the load-enable rise lands at index 0.
  assign load_rise = coef_load_en & ~load_q;
  assign wr_idx    = load_rise ? '0 : idx;
  assign tap_ok    = (cfg_tap_count != '0) && (cfg_tap_count <= MAXT);
  // Held low while reset is asserted even though state already reads IDLE.
  assign in_ready  = s00_axi_aresetn && (state == IDLE)
                   && !coef_load_en && tap_ok;
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);
  assign out_ch    = ch_lat;
  assign mac_en    = (state == MAC);

  fir_mac #(
    .AW    (C_DATA_WIDTH),
    .BW    (C_COEF_WIDTH),
    .ACC_W (C_ACC_WIDTH)
  ) u_mac (
    .clk   (s00_axi_aclk),
    .rst_n (s00_axi_aresetn),
    .clr   (accept),
    .en    (mac_en),
    .a     (dline[ch_lat][k]),
    .b     (coef[k]),
    .acc   (out_data)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state     <= IDLE;
      idx       <= '0;
      t_lat     <= '0;
      k         <= '0;
      ch_lat    <= '0;
      load_q    <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < C_MAX_TAPS; i++) begin
        coef[i] <= '0;
      end
      for (int c = 0; c < C_NUM_CH; c++) begin
        for (int i = 0; i < C_MAX_TAPS; i++) begin
          dline[c][i] <= '0;
        end
      end
    end else begin
      load_q <= coef_load_en;
      if (load_rise) begin
        idx <= '0;
      end
      unique case (state)
        IDLE: begin
          if (coef_load_en) begin
            if (coef_wr) begin
              if (wr_idx < MAXT) begin
                coef[wr_idx[KW-1:0]] <= coef_data;
                idx <= wr_idx + TW'(1);
              end else begin
                err <= 1'b1;
              end
            end
          end else if (!tap_ok) begin
            err <= 1'b1;
          end else if (accept) begin
            for (int i = C_MAX_TAPS - 1; i > 0; i--) begin
              dline[in_ch][i] <= dline[in_ch][i-1];
            end
            dline[in_ch][0] <= in_data;
            t_lat  <= cfg_tap_count;
            ch_lat <= in_ch;
            k      <= '0;
            state  <= MAC;
          end
        end
        MAC: begin
          k <= k + KW'(1);
          if ({1'b0, k} == t_lat - TW'(1)) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
